// File: rtl/sort4_pkg.sv
// Shared types and constants for the 4-entry sort controller: state encoding,
// stage numbering and the compare-swap pair map of the 3-stage network.
package sort4_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] STG0 = 2'd0;
  localparam logic [1:0] STG1 = 2'd1;
  localparam logic [1:0] STG2 = 2'd2;

  // Pair A / pair B slot indices per stage; stage 2 has only pair A.
  localparam logic [1:0] STG0_A_I = 2'd0, STG0_A_J = 2'd1, STG0_B_I = 2'd2, STG0_B_J = 2'd3;
  localparam logic [1:0] STG1_A_I = 2'd0, STG1_A_J = 2'd2, STG1_B_I = 2'd1, STG1_B_J = 2'd3;
  localparam logic [1:0] STG2_A_I = 2'd1, STG2_A_J = 2'd2;

  // Packed {a_i, a_j, b_i, b_j}; stage 2 repeats pair A in the unused B slot.
  function automatic logic [7:0] stage_pairs(input logic [1:0] stg);
    logic [7:0] pairs;
    case (stg)
      STG0:    pairs = {STG0_A_I, STG0_A_J, STG0_B_I, STG0_B_J};
      STG1:    pairs = {STG1_A_I, STG1_A_J, STG1_B_I, STG1_B_J};
      default: pairs = {STG2_A_I, STG2_A_J, STG2_A_I, STG2_A_J};
    endcase
    return pairs;
  endfunction

endpackage

// File: rtl/sort4_cmp_swap.sv
// Combinational compare-swap element: o_first/o_second are the pair in the
// requested order; equal values pass through unswapped.
module sort4_cmp_swap
  import sort4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ascending,
  output logic [WIDTH-1:0] o_first,
  output logic [WIDTH-1:0] o_second
);

  logic w_swap;

  assign w_swap   = i_ascending ? (i_a > i_b) : (i_a < i_b);
  assign o_first  = w_swap ? i_b : i_a;
  assign o_second = w_swap ? i_a : i_b;

endmodule

// File: rtl/sort4_controller.sv
// Sort sequencing controller: owns the 4-slot register bank, handles one-hot
// loads, and runs a 3-stage compare-swap network one stage per clock on start.
module sort4_controller
  import sort4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [3:0]       load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic             ascending,
  output logic [WIDTH-1:0] sorted_num0,
  output logic [WIDTH-1:0] sorted_num1,
  output logic [WIDTH-1:0] sorted_num2,
  output logic [WIDTH-1:0] sorted_num3,
  output logic [3:0]       loaded_mask,
  output logic             busy,
  output logic             done,
  output logic             load_err,
  output logic             start_err
);

  state_t           r_state, w_state_next;
  logic [1:0]       r_stage, w_stage_next;
  logic             r_asc, w_asc_next;
  logic [WIDTH-1:0] r_num [4];
  logic [WIDTH-1:0] w_num_next [4];
  logic [3:0]       r_mask, w_mask_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_load_err, w_load_err_next;
  logic             r_start_err, w_start_err_next;

  logic             w_sorting, w_sel_onehot, w_load_ok, w_start_ok;
  logic [7:0]       w_pairs;
  logic [1:0]       w_idx_i [2];
  logic [1:0]       w_idx_j [2];
  logic [WIDTH-1:0] w_first [2];
  logic [WIDTH-1:0] w_second [2];

  assign w_sorting    = (r_state == ST_SORT);
  assign w_sel_onehot = (load_sel != 4'b0000) && ((load_sel & (load_sel - 4'd1)) == 4'b0000);
  assign w_load_ok    = load_en && !w_sorting && w_sel_onehot;
  assign w_start_ok   = start && !w_sorting && !load_en && (r_mask == 4'hF);

  assign w_pairs    = stage_pairs(r_stage);
  assign w_idx_i[0] = w_pairs[7:6];
  assign w_idx_j[0] = w_pairs[5:4];
  assign w_idx_i[1] = w_pairs[3:2];
  assign w_idx_j[1] = w_pairs[1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_swap
      sort4_cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
        .i_a         (r_num[w_idx_i[gi]]),
        .i_b         (r_num[w_idx_j[gi]]),
        .i_ascending (r_asc),
        .o_first     (w_first[gi]),
        .o_second    (w_second[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_stage     <= STG0;
      r_asc       <= 1'b1;
      for (int k = 0; k < 4; k++) r_num[k] <= '0;
      r_mask      <= 4'b0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_err  <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stage     <= w_stage_next;
      r_asc       <= w_asc_next;
      for (int k = 0; k < 4; k++) r_num[k] <= w_num_next[k];
      r_mask      <= w_mask_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_load_err  <= w_load_err_next;
      r_start_err <= w_start_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stage_next = r_stage;
    w_asc_next   = r_asc;
    case (r_state)
      ST_SORT: begin
        if (r_stage == STG2) begin
          w_state_next = ST_DONE;
          w_stage_next = STG0;
        end else begin
          w_stage_next = r_stage + 2'd1;
        end
      end
      default: begin
        if (w_start_ok) begin
          w_state_next = ST_SORT;
          w_stage_next = STG0;
          w_asc_next   = ascending;
        end else if (w_load_ok) begin
          w_state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_num_next[k] = r_num[k];
    w_mask_next      = r_mask;
    w_done_next      = r_done;
    w_busy_next      = (w_state_next == ST_SORT);
    w_load_err_next  = load_en && !w_load_ok;
    w_start_err_next = start && !w_start_ok;
    if (w_sorting) begin
      w_num_next[w_idx_i[0]] = w_first[0];
      w_num_next[w_idx_j[0]] = w_second[0];
      if (r_stage != STG2) begin
        w_num_next[w_idx_i[1]] = w_first[1];
        w_num_next[w_idx_j[1]] = w_second[1];
      end else begin
        w_mask_next = 4'b0000;
        w_done_next = 1'b1;
      end
    end else if (w_load_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (load_sel[k]) w_num_next[k] = load_data;
      end
      w_mask_next = r_mask | load_sel;
      w_done_next = 1'b0;
    end else if (w_start_ok) begin
      w_done_next = 1'b0;
    end
  end

  assign sorted_num0 = r_num[0];
  assign sorted_num1 = r_num[1];
  assign sorted_num2 = r_num[2];
  assign sorted_num3 = r_num[3];
  assign loaded_mask = r_mask;
  assign busy        = r_busy;
  assign done        = r_done;
  assign load_err    = r_load_err;
  assign start_err   = r_start_err;

endmodule

// File: tb/tb_sort4_controller.sv
// Scoreboard bench for sort4_controller: stimulus pushes expected sorted
// results, a negedge monitor pops them when done rises.
module tb_sort4_controller;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_en;
  logic [3:0]   load_sel;
  logic [W-1:0] load_data;
  logic         start;
  logic         ascending;
  logic [W-1:0] sorted_num0, sorted_num1, sorted_num2, sorted_num3;
  logic [3:0]   loaded_mask;
  logic         busy, done, load_err, start_err;

  int           checks = 0;
  int           failures = 0;
  logic [15:0]  exp_q [$];
  bit           abort_pending = 1'b0;
  logic [W-1:0] model [4];
  logic [3:0]   exp_mask;

  always #5 clk = ~clk;

  sort4_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_sel    (load_sel),
    .load_data   (load_data),
    .start       (start),
    .ascending   (ascending),
    .sorted_num0 (sorted_num0),
    .sorted_num1 (sorted_num1),
    .sorted_num2 (sorted_num2),
    .sorted_num3 (sorted_num3),
    .loaded_mask (loaded_mask),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err),
    .start_err   (start_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] dut_nums();
    return {sorted_num3, sorted_num2, sorted_num1, sorted_num0};
  endfunction

  function automatic logic [15:0] pack_model();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = model[i];
    return r;
  endfunction

  // Reference: the four slot values sorted by value, ascending or descending.
  function automatic logic [15:0] model_sort(input logic asc);
    int q [$];
    logic [15:0] r;
    for (int i = 0; i < 4; i++) q.push_back(int'(model[i]));
    if (asc) q.sort();
    else     q.rsort();
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(q[i]);
    return r;
  endfunction

  task automatic cyc(input logic le, input logic [3:0] sel, input logic [W-1:0] data,
                     input logic st, input logic asc);
    @(negedge clk);
    load_en = le; load_sel = sel; load_data = data; start = st; ascending = asc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] sel, input logic [W-1:0] data, input logic exp_err);
    cyc(1'b1, sel, data, 1'b0, 1'b1);
    chk("load_err", load_err, exp_err);
    if (!exp_err) begin
      for (int k = 0; k < 4; k++) if (sel[k]) model[k] = data;
      exp_mask = exp_mask | sel;
      chk("load_clears_done", done, 1'b0);
    end
    chk("load_mask", loaded_mask, exp_mask);
    chk("load_nums", dut_nums(), pack_model());
    $display("load sel=%b data=%0h err=%0b mask=%b", sel, data, load_err, loaded_mask);
  endtask

  task automatic load_all(input logic [W-1:0] v0, input logic [W-1:0] v1,
                          input logic [W-1:0] v2, input logic [W-1:0] v3);
    do_load(4'b0001, v0, 1'b0);
    do_load(4'b0010, v1, 1'b0);
    do_load(4'b0100, v2, 1'b0);
    do_load(4'b1000, v3, 1'b0);
  endtask

  task automatic start_sort(input logic asc, input logic toggle, input logic load_during);
    logic [15:0] e;
    cyc(1'b0, 4'b0000, '0, 1'b1, asc);
    chk("start_err_ok", start_err, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    chk("done_after_start", done, 1'b0);
    e = model_sort(asc);
    exp_q.push_back(e);
    for (int s = 0; s < 3; s++) begin
      if (load_during && s == 0) begin
        cyc(1'b1, 4'b0001, 4'hF, 1'b0, toggle ? ~asc : asc);
        chk("load_err_busy", load_err, 1'b1);
      end else begin
        cyc(1'b0, 4'b0000, '0, 1'b0, toggle ? ~asc : asc);
      end
    end
    chk("done_after_3", done, 1'b1);
    chk("busy_after_3", busy, 1'b0);
    for (int i = 0; i < 4; i++) model[i] = e[i*4 +: 4];
    exp_mask = 4'b0000;
    $display("sort asc=%0b toggle=%0b expect=%04h got=%04h", asc, toggle, e, dut_nums());
  endtask

  // Monitor: compare each done rising edge with the oldest expected result.
  initial begin : monitor
    logic        prev_done;
    int          busy_cnt;
    logic [15:0] e;
    prev_done = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (done && !prev_done) begin
          chk("expect_pending", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sorted", dut_nums(), e);
            chk("done_mask", loaded_mask, 4'b0000);
          end
        end
        if (busy) busy_cnt++;
        else if (busy_cnt != 0) begin
          if (!abort_pending) chk("busy_len", busy_cnt, 3);
          abort_pending = 1'b0;
          busy_cnt = 0;
        end
      end
      prev_done = done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          order [4];
    int          t, j;
    logic [W-1:0] v [4];
    rst_n = 1'b0; load_en = 1'b0; load_sel = 4'b0; load_data = '0; start = 1'b0; ascending = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    exp_mask = 4'b0000;
    #3;
    chk("rst_nums", dut_nums(), 16'h0000);
    chk("rst_mask", loaded_mask, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_errs", {load_err, start_err}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_all(4'd9, 4'd3, 4'd7, 4'd1);
    start_sort(1'b1, 1'b0, 1'b0);
    load_all(4'd9, 4'd3, 4'd7, 4'd1);
    start_sort(1'b0, 1'b1, 1'b0);
    load_all(4'd5, 4'd5, 4'd2, 4'd5);
    start_sort(1'b1, 1'b0, 1'b0);
    load_all(4'h0, 4'hF, 4'h0, 4'hF);
    start_sort(1'b1, 1'b0, 1'b0);

    // Incomplete mask: start rejected.
    do_load(4'b0001, 4'd4, 1'b0);
    do_load(4'b0010, 4'd8, 1'b0);
    do_load(4'b0100, 4'd2, 1'b0);
    cyc(1'b0, 4'b0000, '0, 1'b1, 1'b1);
    chk("start_err_mask", start_err, 1'b1);
    chk("busy_mask", busy, 1'b0);
    chk("done_mask_rej", done, 1'b0);
    cyc(1'b0, 4'b0000, '0, 1'b0, 1'b1);
    chk("start_err_pulse", start_err, 1'b0);
    chk("busy_idle", busy, 1'b0);

    // Non-one-hot select.
    do_load(4'b0011, 4'hA, 1'b1);
    do_load(4'b0000, 4'hA, 1'b1);
    cyc(1'b0, 4'b0000, '0, 1'b0, 1'b1);
    chk("load_err_pulse", load_err, 1'b0);

    // Simultaneous load + start: load wins, start rejected.
    cyc(1'b1, 4'b1000, 4'd6, 1'b1, 1'b1);
    model[3] = 4'd6; exp_mask = 4'hF;
    chk("sim_load_err", load_err, 1'b0);
    chk("sim_start_err", start_err, 1'b1);
    chk("sim_busy", busy, 1'b0);
    chk("sim_nums", dut_nums(), pack_model());
    start_sort(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a sort.
    load_all(4'd1, 4'd2, 4'd3, 4'd4);
    cyc(1'b0, 4'b0000, '0, 1'b1, 1'b0);
    cyc(1'b0, 4'b0000, '0, 1'b0, 1'b0);
    #2;
    abort_pending = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_nums", dut_nums(), 16'h0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_mask", loaded_mask, 4'b0000);
    exp_q.delete();
    exp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 4'b0000, '0, 1'b0, 1'b1);
    load_all(4'd12, 4'd0, 4'd7, 4'd3);
    start_sort(1'b1, 1'b0, 1'b0);

    // Randomized sorts with shuffled load order and occasional overwrites.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) begin
        order[i] = i;
        v[i] = 4'($urandom_range(0, 15));
      end
      for (int i = 3; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 4; i++) do_load(4'(1 << order[i]), v[order[i]], 1'b0);
      if ($urandom_range(0, 3) == 0)
        do_load(4'(1 << $urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0);
      if ($urandom_range(0, 4) == 0)
        do_load(4'b0101, 4'($urandom_range(0, 15)), 1'b1);
      start_sort(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) cyc(1'b0, 4'b0000, '0, 1'b0, 1'b1);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
